// File: rtl/rx_ctrl_phy.sv
// rx_ctrl_phy: UART-style receiver (start, 8 data bits MSB first, 2 stop bits) with a bit period set at run time
module rx_ctrl_phy #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        rx,
    input  logic [19:0] tbit_period,
    output logic [7:0]  data_rx,
    output logic        done_rx,
    output logic        err_frame,
    output logic        busy_rx
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE, S_ERR} state_e;
    state_e st_q, st_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic rx_d_q;
    logic [19:0] cnt_q, cnt_d, p_q, p_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sr_q, sr_d, data_q, data_d;
    logic err_q, err_d;
    logic rx_s, fall, smp, bit_end;
    assign rx_s = sync_q[SYNC_STAGES-1];
    assign fall = rx_d_q & ~rx_s;
    assign smp = cnt_q == (p_q >> 1);
    assign bit_end = cnt_q == p_q - 20'd1;
    assign data_rx = data_q;
    assign done_rx = st_q == S_DONE;
    assign err_frame = err_q;
    assign busy_rx = st_q != S_IDLE;
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            rx_d_q <= 1'b1;
            st_q <= S_IDLE;
            cnt_q <= '0;
            p_q <= '0;
            bit_q <= '0;
            sr_q <= '0;
            data_q <= '0;
            err_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_d_q <= rx_s;
            st_q <= st_d;
            cnt_q <= cnt_d;
            p_q <= p_d;
            bit_q <= bit_d;
            sr_q <= sr_d;
            data_q <= data_d;
            err_q <= err_d;
        end
    end
    // Stop is judged mid-bit so back-to-back frames keep ~1.5 bit times of resync margin
    always_comb begin
        st_d = st_q;
        cnt_d = bit_end ? '0 : cnt_q + 20'd1;
        p_d = p_q;
        bit_d = bit_q;
        sr_d = sr_q;
        data_d = data_q;
        err_d = 1'b0;
        case (st_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    st_d = S_START;
                    p_d = tbit_period;
                end
            end
            S_START: begin
                if (smp && rx_s) begin
                    st_d = S_IDLE;
                    cnt_d = '0;
                end else if (bit_end) begin
                    st_d = S_DATA;
                    bit_d = 3'd7;
                end
            end
            S_DATA: begin
                if (smp) sr_d = {sr_q[6:0], rx_s};
                if (bit_end) begin
                    bit_d = bit_q - 3'd1;
                    if (bit_q == 3'd0) st_d = S_STOP;
                end
            end
            S_STOP: begin
                if (smp) begin
                    cnt_d = '0;
                    st_d = rx_s ? S_DONE : S_ERR;
                    err_d = ~rx_s;
                    data_d = rx_s ? sr_q : data_q;
                end
            end
            S_DONE: begin
                cnt_d = '0;
                st_d = S_IDLE;
            end
            S_ERR: begin
                cnt_d = '0;
                if (rx_s) st_d = S_IDLE;
            end
            default: st_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_rx_ctrl_phy.sv
// tb_rx_ctrl_phy: drives serial frames with a behavioural transmitter and checks received bytes, strobes and latency
module tb_rx_ctrl_phy;
    localparam int SYNC = 2;
    logic clk_sys = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic [19:0] tbit_period = 20'd16;
    logic [7:0] data_rx;
    logic done_rx, err_frame, busy_rx;
    int cyc = 0, tests = 0, fails = 0;
    int err_cnt = 0, both_cnt = 0, busy_cyc = 0, done_cyc = 0;
    logic [7:0] got[$];
    logic [7:0] last_good = 8'h00;

    rx_ctrl_phy #(.SYNC_STAGES(SYNC)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .rx(rx), .tbit_period(tbit_period),
        .data_rx(data_rx), .done_rx(done_rx), .err_frame(err_frame), .busy_rx(busy_rx)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (rst_n) begin
            if (done_rx) begin
                got.push_back(data_rx);
                done_cyc = cyc;
            end
            if (err_frame) err_cnt++;
            if (done_rx && err_frame) both_cnt++;
            if (busy_rx) busy_cyc++;
        end
    end

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // chg_at: frame bit index (0 = start, 1 = D7 ...) in whose middle tbit_period is rewritten
    task automatic send_frame(input logic [7:0] b, input int p, input logic stop_v, input int chg_at, input logic [19:0] new_p);
        logic [10:0] bits;
        bits = {1'b0, b, stop_v, stop_v};
        for (int i = 10; i >= 0; i--) begin
            if (10 - i == chg_at) begin
                drive(bits[i], p / 2);
                tbit_period = new_p;
                drive(bits[i], p - p / 2);
            end else begin
                drive(bits[i], p);
            end
        end
    endtask

    task automatic wait_got(input int n, input int budget);
        for (int k = 0; k < budget && got.size() < n; k++) @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        tests++; if (data_rx !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", data_rx); end
        tests++; if (done_rx !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done_rx); end
        tests++; if (err_frame !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err_frame); end
        tests++; if (busy_rx !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_rx); end
        @(posedge clk_sys); #1;
        rst_n = 1'b1;
        drive(1'b1, 5);
    endtask

    task automatic test_good_frame;
        int p, base, eb, c0, lat;
        logic [7:0] b;
        for (int n = 0; n < 6; n++) begin
            p = (n < 2) ? 16 : int'($urandom_range(4, 40));
            b = (n == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            tbit_period = 20'(p);
            base = got.size();
            eb = err_cnt;
            c0 = cyc;
            send_frame(b, p, 1'b1, -1, 20'd0);
            wait_got(base + 1, 4 * p);
            lat = SYNC + 2 + 9 * p + p / 2;
            tests++;
            if (got.size() != base + 1) begin
                fails++; $display("FAIL good_count: got %0d strobes expected 1 (P=%0d)", got.size() - base, p);
            end else begin
                tests++; if (got[base] !== b) begin fails++; $display("FAIL good_data: got %h expected %h (P=%0d)", got[base], b, p); end
                tests++; if (done_cyc - c0 != lat) begin fails++; $display("FAIL good_latency: got %0d expected %0d (P=%0d)", done_cyc - c0, lat, p); end
            end
            tests++; if (err_cnt != eb) begin fails++; $display("FAIL good_err: got %0d expected 0", err_cnt - eb); end
            tests++; if (data_rx !== b) begin fails++; $display("FAIL good_hold: got %h expected %h", data_rx, b); end
            last_good = b;
        end
    endtask

    task automatic test_false_start;
        int base, eb, bb;
        tbit_period = 20'd16;
        base = got.size();
        eb = err_cnt;
        bb = busy_cyc;
        drive(1'b0, 5);
        drive(1'b1, 64);
        tests++; if (got.size() != base) begin fails++; $display("FAIL false_done: got %0d expected 0", got.size() - base); end
        tests++; if (err_cnt != eb) begin fails++; $display("FAIL false_err: got %0d expected 0", err_cnt - eb); end
        tests++; if (busy_cyc - bb != 9) begin fails++; $display("FAIL false_busy: got %0d expected 9", busy_cyc - bb); end
        tests++; if (data_rx !== last_good) begin fails++; $display("FAIL false_data: got %h expected %h", data_rx, last_good); end
    endtask

    task automatic test_frame_error;
        int base, eb;
        tbit_period = 20'd16;
        base = got.size();
        eb = err_cnt;
        send_frame(8'h3C, 16, 1'b0, -1, 20'd0);
        drive(1'b0, 100);
        drive(1'b1, 32);
        tests++; if (err_cnt - eb != 1) begin fails++; $display("FAIL ferr_count: got %0d expected 1", err_cnt - eb); end
        tests++; if (got.size() != base) begin fails++; $display("FAIL ferr_done: got %0d expected 0", got.size() - base); end
        tests++; if (data_rx !== last_good) begin fails++; $display("FAIL ferr_data: got %h expected %h", data_rx, last_good); end
        send_frame(8'h81, 16, 1'b1, -1, 20'd0);
        wait_got(base + 1, 64);
        tests++;
        if (got.size() != base + 1) begin fails++; $display("FAIL ferr_next_count: got %0d expected 1", got.size() - base); end
        else begin
            tests++; if (got[base] !== 8'h81) begin fails++; $display("FAIL ferr_next_data: got %h expected 81", got[base]); end
        end
        tests++; if (err_cnt - eb != 1) begin fails++; $display("FAIL ferr_next_err: got %0d expected 1", err_cnt - eb); end
        last_good = 8'h81;
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_q[$];
        int base, eb;
        exp_q = '{8'h00, 8'hFF, 8'h55};
        tbit_period = 20'd868;
        base = got.size();
        eb = err_cnt;
        foreach (exp_q[i]) send_frame(exp_q[i], 868, 1'b1, -1, 20'd0);
        wait_got(base + 3, 4 * 868);
        tests++;
        if (got.size() != base + 3) begin fails++; $display("FAIL b2b_count: got %0d expected 3", got.size() - base); end
        else begin
            foreach (exp_q[i]) begin
                tests++; if (got[base + i] !== exp_q[i]) begin fails++; $display("FAIL b2b_data%0d: got %h expected %h", i, got[base + i], exp_q[i]); end
            end
        end
        tests++; if (err_cnt != eb) begin fails++; $display("FAIL b2b_err: got %0d expected 0", err_cnt - eb); end
        last_good = 8'h55;
    endtask

    task automatic test_reset_mid_frame;
        int base, eb;
        logic [7:0] r;
        r = 8'($urandom_range(0, 255));
        tbit_period = 20'd16;
        base = got.size();
        eb = err_cnt;
        drive(1'b0, 16);
        for (int i = 7; i >= 4; i--) drive(r[i], 16);
        drive(r[3], 8);
        rst_n = 1'b0;
        #2;
        tests++; if (data_rx !== 8'h00) begin fails++; $display("FAIL midrst_data: got %h expected 00", data_rx); end
        tests++; if (busy_rx !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy_rx); end
        tests++; if (done_rx !== 1'b0 || err_frame !== 1'b0) begin fails++; $display("FAIL midrst_strobe: got %b%b expected 00", done_rx, err_frame); end
        rx = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 48);
        tests++; if (got.size() != base || err_cnt != eb) begin fails++; $display("FAIL midrst_nostrobe: got %0d/%0d expected 0/0", got.size() - base, err_cnt - eb); end
        send_frame(8'h12, 16, 1'b1, -1, 20'd0);
        wait_got(base + 1, 64);
        tests++;
        if (got.size() != base + 1) begin fails++; $display("FAIL midrst_next_count: got %0d expected 1", got.size() - base); end
        else begin
            tests++; if (got[base] !== 8'h12) begin fails++; $display("FAIL midrst_next_data: got %h expected 12", got[base]); end
        end
        last_good = 8'h12;
    endtask

    task automatic test_period_change;
        int base;
        logic [7:0] b2;
        b2 = 8'($urandom_range(0, 255));
        tbit_period = 20'd20;
        base = got.size();
        send_frame(8'h6B, 20, 1'b1, 3, 20'd40);
        send_frame(b2, 40, 1'b1, -1, 20'd0);
        wait_got(base + 2, 160);
        tests++;
        if (got.size() != base + 2) begin fails++; $display("FAIL pchg_count: got %0d expected 2", got.size() - base); end
        else begin
            tests++; if (got[base] !== 8'h6B) begin fails++; $display("FAIL pchg_first: got %h expected 6b", got[base]); end
            tests++; if (got[base + 1] !== b2) begin fails++; $display("FAIL pchg_second: got %h expected %h", got[base + 1], b2); end
        end
    endtask

    task automatic test_strobe_exclusive;
        tests++; if (both_cnt != 0) begin fails++; $display("FAIL strobe_overlap: got %0d cycles expected 0", both_cnt); end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_false_start;
        test_frame_error;
        test_back_to_back;
        test_reset_mid_frame;
        test_period_change;
        test_strobe_exclusive;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
